// File: rtl/shift_add_mul.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per RUN cycle.
// Define SHIFT_ADD_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one conditional add and shift per cycle
// DONE  | product valid, done pulses for one cycle
module shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  assign acc_sum = mplr[0] ? (acc + mcand) : acc;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
          if (mplr == '0) begin
            product <= acc;
            state   <= DONE;
          end else
`endif
          begin
            acc   <= acc_sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - 1'b1;
            // last step: publish the sum being formed on this edge
            if (cnt == CW'(1)) begin
              product <= acc_sum;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: 16-bit directed cases and an 8-bit random sweep.
// Expected latency follows SHIFT_ADD_MUL_EARLY_TERM_EN when the bench is built with it.
module tb_shift_add_mul;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start16 = 1'b0, start8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy16, done16, busy8, done8;
  logic [31:0] product16;
  logic [15:0] product8;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q16[$];
  exp_t q8[$];
  logic [31:0] last16 = '0;
  logic [15:0] last8 = '0;
  logic        pd16 = 1'b0, pd8 = 1'b0;

  shift_add_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  shift_add_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference latency: bits of b still to consume plus the detecting cycle, capped at w.
  function automatic int exp_lat(input int w, input logic [31:0] bv);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    int bl = 0;
    for (int i = 0; i < 32; i++) if (bv[i]) bl = i + 1;
    return (bl + 1 < w) ? bl + 1 : w;
`else
    return w;
`endif
  endfunction

  task automatic issue(input bit s8, input logic [31:0] av, input logic [31:0] bv, input bit rel);
    exp_t e;
    @(negedge clk);
    if (s8) begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
    else begin a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1; end
    if (rel) rst_n = 1'b1;
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
    e.prod = {32'b0, av} * {32'b0, bv};
    e.cyc  = cyc + exp_lat(s8 ? 8 : 16, bv);
    if (s8) q8.push_back(e); else q16.push_back(e);
  endtask

  task automatic wait_done(input bit s8);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (s8 ? done8 : done16) got = 1'b1;
      else chk((s8 ? busy8 : busy16) == 1'b1, "busy_in_run", {63'b0, s8 ? busy8 : busy16}, 64'd1);
    end
    chk(got, "done_timeout", {63'b0, got}, 64'd1);
    if (got) chk((s8 ? busy8 : busy16) == 1'b0, "busy_in_done", {63'b0, s8 ? busy8 : busy16}, 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last16 = '0;
      pd16   = 1'b0;
    end else begin
      if (done16) begin
        chk(!pd16, "done16_pulse", {63'b0, pd16}, 64'd0);
        if (q16.size() == 0) chk(1'b0, "done16_unexpected", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          chk(product16 == e.prod[31:0], "product16", {32'b0, product16}, e.prod);
          chk(cyc == e.cyc, "latency16", 64'(cyc), 64'(e.cyc));
        end
        last16 = product16;
      end else begin
        chk(product16 == last16, "product16_hold", {32'b0, product16}, {32'b0, last16});
      end
      pd16 = done16;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last8 = '0;
      pd8   = 1'b0;
    end else begin
      if (done8) begin
        chk(!pd8, "done8_pulse", {63'b0, pd8}, 64'd0);
        if (q8.size() == 0) chk(1'b0, "done8_unexpected", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          chk(product8 == e.prod[15:0], "product8", {48'b0, product8}, e.prod);
          chk(cyc == e.cyc, "latency8", 64'(cyc), 64'(e.cyc));
        end
        last8 = product8;
      end else begin
        chk(product8 == last8, "product8_hold", {48'b0, product8}, {48'b0, last8});
      end
      pd8 = done8;
    end
  end

  initial begin
    logic [31:0] ra, rb;
    #2 rst_n = 1'b0;
    #1;
    chk(busy16 == 1'b0 && done16 == 1'b0, "reset16_flags", {62'b0, busy16, done16}, 64'd0);
    chk(product16 == '0, "reset16_product", {32'b0, product16}, 64'd0);
    chk(busy8 == 1'b0 && done8 == 1'b0, "reset8_flags", {62'b0, busy8, done8}, 64'd0);
    chk(product8 == '0, "reset8_product", {48'b0, product8}, 64'd0);
    repeat (3) @(negedge clk);

    // first edge after release accepts start
    issue(1'b0, 32'd17, 32'd5, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 32'hFFFF, 32'hFFFF, 1'b0);
    wait_done(1'b0);
    issue(1'b0, 32'd1234, 32'd0, 1'b0);
    wait_done(1'b0);
    issue(1'b0, 32'd0, 32'd999, 1'b0);
    wait_done(1'b0);

    // start pulse mid-run must be ignored
    issue(1'b0, 32'd17, 32'd5, 1'b0);
    @(negedge clk);
    chk(busy16 == 1'b1, "busy_before_pulse", {63'b0, busy16}, 64'd1);
    a16 = 16'd3; b16 = 16'd3; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5;
    wait_done(1'b0);

    // asynchronous reset in the middle of an operation
    issue(1'b0, 32'd17, 32'd5, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(busy16 == 1'b0, "abort_busy", {63'b0, busy16}, 64'd0);
    chk(done16 == 1'b0, "abort_done", {63'b0, done16}, 64'd0);
    chk(product16 == '0, "abort_product", {32'b0, product16}, 64'd0);
    q16.delete();
    repeat (3) @(negedge clk);
    issue(1'b0, 32'd6, 32'd7, 1'b1);
    wait_done(1'b0);
    repeat (20) @(negedge clk);

    issue(1'b1, 32'd255, 32'd255, 1'b0);
    wait_done(1'b1);
    issue(1'b1, 32'd200, 32'd0, 1'b0);
    wait_done(1'b1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      issue(1'b1, ra, rb, 1'b0);
      wait_done(1'b1);
    end
    repeat (4) @(negedge clk);
    chk(q16.size() == 0, "q16_drained", 64'(q16.size()), 64'd0);
    chk(q8.size() == 0, "q8_drained", 64'(q8.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  multiplicand, unsigned; captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  multiplier, unsigned; captured on the accepted start edge.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  single-cycle pulse; product is valid.
REQ-009 SHALL have port product  output  2*WIDTH  registered result; held until the next done.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE.
REQ-011 SHALL, in IDLE with start=1 at edge E, load mcand={WIDTH zeros,a}, load mplr=b, clear acc (2*WIDTH bits), set cnt=WIDTH, and go to RUN.
REQ-012 SHALL, at each RUN edge, perform: if mplr[0] then acc+=mcand; then mcand<<=1, mplr>>=1, cnt-=1; arithmetic is modulo 2^(2*WIDTH) and cannot overflow.
REQ-013 SHALL move RUN->DONE on the edge where cnt goes 1->0, writing the final acc into product on that same edge.
REQ-014 SHALL hold done=1 for exactly the one cycle in DONE, then return to IDLE on the next edge; busy=0 in DONE and IDLE.
REQ-015 SHALL give latency without early termination: done high in the cycle following edge E+WIDTH; back-to-back start is accepted one cycle after done at the earliest.
REQ-016 SHALL ignore start while in RUN or DONE, with no effect on a, b or the result.
REQ-017 SHALL leave product unchanged except on the DONE-entry edge, including while a, b or start toggle.
REQ-018 SHALL treat a=0 or b=0 as normal operation, producing product=0 with normal latency (subject to REQ-024).
REQ-019 SHALL compute product=a*b exactly for all operand values, including a=b=2^WIDTH-1.

Reset
REQ-020 SHALL, on rst_n low, immediately and asynchronously force state=IDLE, busy=0, done=0, product=0, acc=0, cnt=0.
REQ-021 SHALL abort any operation in flight when reset asserts mid-operation; after release no done is produced for the aborted operation.
REQ-022 SHALL accept start on the first rising edge at which rst_n is high.

Configuration
REQ-023 SHALL use macro SHIFT_ADD_MUL_EARLY_TERM_EN.
REQ-024 SHALL, with the macro defined, on any RUN edge where mplr==0 before the step, skip the add and go to DONE, latching acc into product; done then follows edge E+min(bitlen(b)+1, WIDTH), with b=0 giving done after E+1.
REQ-025 SHALL, with the macro undefined, always take exactly WIDTH RUN cycles per REQ-015, and the mplr==0 check SHALL not be synthesised.

Verification
REQ-026 SHALL cover: WIDTH=16, a=17, b=5, start at edge E -> product=85, done high only in the cycle after E+16 (macro off) or after E+4 (macro on).
REQ-027 SHALL cover: WIDTH=16, a=b=0xFFFF -> product=0xFFFE0001, done after E+16 in both builds.
REQ-028 SHALL cover: a=1234, b=0 -> product=0; done after E+16 (macro off) or after E+1 (macro on).
REQ-029 SHALL cover: during RUN of 17*5, pulse start with a=3, b=3 -> result still 85, exactly one done, busy continuous.
REQ-030 SHALL cover: reset mid-operation, rst_n low at E+5 during 17*5 -> busy, done and product go to 0 without waiting for a clock edge, no done after release; a new 6*7 then yields 42.
REQ-031 SHALL cover: WIDTH=8 random sweep of 1000 operand pairs -> every product equals the a*b reference and each done is a single-cycle pulse.
